multi_write_port: RTL and testbench

MULTI_WRITE_PORT -- requirements
Module: multi_write_port

---
 rtl/multi_write_port_pkg.sv | 22 ++
 rtl/multi_write_port_rr_arbiter.sv | 48 ++++
 rtl/multi_write_port.sv | 140 ++++++++++++++
 tb/tb_multi_write_port.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_write_port_pkg.sv
// Shared constants and the write-buffer entry record for the multi-port register write path.
package multi_write_port_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_DEPTH    = 4;

    // Entry fields are sized by the default address/data widths.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] wreg;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

    // Pointer width that stays at least one bit wide for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_write_port_rr_arbiter.sv
// Round-robin single-grant arbiter; the search starts at rr_ptr and the pointer moves past each winner.
module rr_arbiter
    import multi_write_port_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt
);

    localparam int PTR_W = clog2_min1(NUM_CH);

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;

    always_comb begin
        int   cand;
        logic found;
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (en && !found && req[PTR_W'(cand)]) begin
                found               = 1'b1;
                gnt[PTR_W'(cand)]   = 1'b1;
                rr_ptr_d            = (cand + 1 == NUM_CH) ? '0 : PTR_W'(cand + 1);
            end
        end
    end

    // A grant always coincides with a handshake because only requesters are granted.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/multi_write_port.sv
// Merges several register-write requesters into one write per cycle through a small FIFO,
// with a youngest-match forwarding lookup over the pending entries.
module multi_write_port
    import multi_write_port_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_writeReg,
    input  logic [NUM_CH*DATA_W-1:0]   ch_writeData,
    input  logic                       ctrl_stall,
    output logic [NUM_REGS-1:0]        out_we,
    output logic [DATA_W-1:0]          out_data,
    input  logic [ADDR_W-1:0]          fwd_reg,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = clog2_min1(DEPTH);

    entry_t           buf_q [DEPTH];
    entry_t           buf_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              has_space;
    logic              grant_en;
    logic              handshake;
    logic              enq;
    logic              deq;
    logic [NUM_CH-1:0] gnt;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] head_reg;
    entry_t            head_entry;

    // A full buffer refuses new work even when the head drains this cycle.
    assign has_space = count_q < CNT_W'(DEPTH);
    assign grant_en  = has_space && !ctrl_reset;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .req        (ch_valid),
        .en         (grant_en),
        .gnt        (gnt)
    );

    assign ch_ready  = gnt;
    assign handshake = |(ch_valid & gnt);

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_reg  = ch_writeReg[i*ADDR_W +: ADDR_W];
                sel_data = ch_writeData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register 0 is hard-wired, so its writes complete the handshake and vanish.
    assign enq = handshake && (sel_reg != '0);

    assign head_entry = buf_q[head_q];
    assign head_reg   = ADDR_W'(head_entry.wreg);
    assign deq        = (count_q != '0) && head_entry.valid && !ctrl_stall && !ctrl_reset;
    assign out_data   = deq ? DATA_W'(head_entry.data) : '0;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
            assign out_we[gi] = deq && (head_reg == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        buf_d  = buf_q;
        head_d = head_q;
        tail_d = tail_q;
        if (enq) begin
            buf_d[tail_q] = '{valid: 1'b1,
                              wreg:  DEF_ADDR_W'(sel_reg),
                              data:  DEF_DATA_W'(sel_data)};
            tail_d = tail_q + PTR_W'(1);
        end
        if (deq) begin
            buf_d[head_q].valid = 1'b0;
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            buf_q   <= buf_d;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest write.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (!ctrl_reset && (fwd_reg != '0) && (CNT_W'(k) < count_q) &&
                buf_q[idx].valid && (ADDR_W'(buf_q[idx].wreg) == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = DATA_W'(buf_q[idx].data);
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_multi_write_port.sv
// Directed bench for multi_write_port: a vector table plus streaming and fill sequences.
module tb_multi_write_port;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic [1:0]  ch_valid;
    logic [1:0]  ch_ready;
    logic [9:0]  ch_writeReg;
    logic [63:0] ch_writeData;
    logic        ctrl_stall;
    logic [31:0] out_we;
    logic [31:0] out_data;
    logic [4:0]  fwd_reg;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    always #5 clock = ~clock;

    multi_write_port dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_writeReg  (ch_writeReg),
        .ch_writeData (ch_writeData),
        .ctrl_stall   (ctrl_stall),
        .out_we       (out_we),
        .out_data     (out_data),
        .fwd_reg      (fwd_reg),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .count        (count)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        stall;
        logic [4:0]  fwd;
        logic [1:0]  e_ready;
        logic [31:0] e_we;
        logic [31:0] e_data;
        logic [2:0]  e_count;
        logic        e_hit;
        logic [31:0] e_fdata;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [1:0] v,
                                input logic [4:0] r0, input logic [31:0] d0,
                                input logic [4:0] r1, input logic [31:0] d1,
                                input logic st, input logic [4:0] fw,
                                input logic [1:0] er, input logic [31:0] ew,
                                input logic [31:0] ed, input logic [2:0] ec,
                                input logic eh, input logic [31:0] ef);
        vec_t t;
        t.rst = rst; t.valid = v; t.r0 = r0; t.d0 = d0; t.r1 = r1; t.d1 = d1;
        t.stall = st; t.fwd = fw; t.e_ready = er; t.e_we = ew; t.e_data = ed;
        t.e_count = ec; t.e_hit = eh; t.e_fdata = ef;
        return t;
    endfunction

    initial begin
        int acc;
        // rst valid r0 d0 r1 d1 stall fwd | ready we data count hit fwd_data
        vecs[0]  = mk(1'b1, 2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0, 5'd3,
                      2'b00, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd5,
                      2'b01, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 2'b00, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd5,
                      2'b00, 32'h20, 32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF);
        vecs[3]  = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd5,
                      2'b00, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 2'b10, 5'd0, 32'h0, 5'd0, 32'h1234, 1'b0, 5'd0,
                      2'b10, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[5]  = mk(1'b0, 2'b11, 5'd9, 32'h90, 5'd10, 32'hA0, 1'b1, 5'd0,
                      2'b01, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[6]  = mk(1'b0, 2'b11, 5'd9, 32'h90, 5'd10, 32'hA0, 1'b1, 5'd9,
                      2'b10, 32'h0, 32'h0, 3'd1, 1'b1, 32'h90);
        vecs[7]  = mk(1'b0, 2'b11, 5'd9, 32'h91, 5'd10, 32'hA0, 1'b1, 5'd10,
                      2'b01, 32'h0, 32'h0, 3'd2, 1'b1, 32'hA0);
        vecs[8]  = mk(1'b0, 2'b11, 5'd9, 32'h91, 5'd10, 32'hA1, 1'b1, 5'd9,
                      2'b10, 32'h0, 32'h0, 3'd3, 1'b1, 32'h91);
        vecs[9]  = mk(1'b0, 2'b11, 5'd9, 32'h91, 5'd10, 32'hA1, 1'b1, 5'd10,
                      2'b00, 32'h0, 32'h0, 3'd4, 1'b1, 32'hA1);
        vecs[10] = mk(1'b0, 2'b11, 5'd9, 32'h91, 5'd10, 32'hA1, 1'b0, 5'd0,
                      2'b00, 32'h200, 32'h90, 3'd4, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 2'b11, 5'd9, 32'h92, 5'd10, 32'hA1, 1'b0, 5'd9,
                      2'b01, 32'h400, 32'hA0, 3'd3, 1'b1, 32'h91);
        vecs[12] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9,
                      2'b00, 32'h0, 32'h0, 3'd3, 1'b1, 32'h92);
        vecs[13] = mk(1'b1, 2'b11, 5'd9, 32'h92, 5'd10, 32'hA1, 1'b0, 5'd9,
                      2'b00, 32'h0, 32'h0, 3'd3, 1'b0, 32'h0);
        vecs[14] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9,
                      2'b00, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[15] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9,
                      2'b00, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[16] = mk(1'b0, 2'b01, 5'd7, 32'hA, 5'd0, 32'h0, 1'b1, 5'd7,
                      2'b01, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        vecs[17] = mk(1'b0, 2'b10, 5'd7, 32'hA, 5'd7, 32'hB, 1'b1, 5'd7,
                      2'b10, 32'h0, 32'h0, 3'd1, 1'b1, 32'hA);
        vecs[18] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7,
                      2'b00, 32'h0, 32'h0, 3'd2, 1'b1, 32'hB);
        vecs[19] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0,
                      2'b00, 32'h0, 32'h0, 3'd2, 1'b0, 32'h0);
        vecs[20] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd7,
                      2'b00, 32'h80, 32'hA, 3'd2, 1'b1, 32'hB);
        vecs[21] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd7,
                      2'b00, 32'h80, 32'hB, 3'd1, 1'b1, 32'hB);
        vecs[22] = mk(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd7,
                      2'b00, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);

        ctrl_reset   = 1'b1;
        ch_valid     = 2'b00;
        ch_writeReg  = '0;
        ch_writeData = '0;
        ctrl_stall   = 1'b0;
        fwd_reg      = '0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            ctrl_reset   = vecs[i].rst;
            ch_valid     = vecs[i].valid;
            ch_writeReg  = {vecs[i].r1, vecs[i].r0};
            ch_writeData = {vecs[i].d1, vecs[i].d0};
            ctrl_stall   = vecs[i].stall;
            fwd_reg      = vecs[i].fwd;
            #1;
            $display("vec %0d ready=%b we=%h data=%h count=%0d hit=%b fwd_data=%h",
                     i, ch_ready, out_we, out_data, count, fwd_hit, fwd_data);
            check($sformatf("v%0d_ready", i), 64'(ch_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d_we", i),    64'(out_we),   64'(vecs[i].e_we));
            check($sformatf("v%0d_data", i),  64'(out_data), 64'(vecs[i].e_data));
            check($sformatf("v%0d_count", i), 64'(count),    64'(vecs[i].e_count));
            check($sformatf("v%0d_hit", i),   64'(fwd_hit),  64'(vecs[i].e_hit));
            check($sformatf("v%0d_fdata", i), 64'(fwd_data), 64'(vecs[i].e_fdata));
        end

        // Back-to-back stream on ch0: one-cycle latency, count steady at 1 under enqueue+dequeue.
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            ch_valid     = 2'b01;
            ch_writeReg  = {5'd0, 5'(k + 1)};
            ch_writeData = {32'd0, 32'(32'h100 + k)};
            ctrl_stall   = 1'b0;
            fwd_reg      = 5'd0;
            #1;
            $display("stream %0d ready=%b we=%h data=%h count=%0d", k, ch_ready, out_we, out_data, count);
            check($sformatf("s%0d_ready", k), 64'(ch_ready), 64'(2'b01));
            check($sformatf("s%0d_count", k), 64'(count), (k == 0) ? 64'd0 : 64'd1);
            check($sformatf("s%0d_we", k), 64'(out_we), (k == 0) ? 64'd0 : 64'(32'd1 << k));
            check($sformatf("s%0d_data", k), 64'(out_data), (k == 0) ? 64'd0 : 64'(32'h100 + k - 1));
        end
        @(negedge clock);
        ch_valid = 2'b00;
        #1;
        $display("stream tail we=%h data=%h count=%0d", out_we, out_data, count);
        check("stream_tail_we", 64'(out_we), 64'(32'h40));
        check("stream_tail_data", 64'(out_data), 64'(32'h105));
        check("stream_tail_count", 64'(count), 64'd1);
        @(negedge clock);
        #1;
        check("stream_drained", 64'(count), 64'd0);

        // From reset, both channels held valid while stalled: alternate grants, ready drops at 4.
        @(negedge clock);
        ctrl_reset = 1'b1;
        @(negedge clock);
        ctrl_reset   = 1'b0;
        ch_valid     = 2'b11;
        ctrl_stall   = 1'b1;
        ch_writeReg  = {5'd12, 5'd11};
        ch_writeData = {32'hC0, 32'hB0};
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clock);
            #1;
            $display("fill cycle %0d ready=%b count=%0d", c, ch_ready, count);
            if (ch_ready == 2'b00) break;
            check($sformatf("fill%0d_grant", acc), 64'(ch_ready), (acc % 2 == 0) ? 64'd1 : 64'd2);
            acc++;
        end
        check("fill_accepts", 64'(acc), 64'd4);
        check("fill_count", 64'(count), 64'd4);
        check("fill_we_stalled", 64'(out_we), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
